// File: rtl/down_counter_timer_pkg.sv
// Shared constants for the counter family.
// State encoding and the default count width.
package down_counter_timer_pkg;

  localparam int COUNTER_WIDTH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down counter / timer.
// One-shot with sticky done, or periodic with auto-reload.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
      done       <= 1'b0;
    end else if (load) begin
      count      <= load_value;
      reload_reg <= load_value;
      done       <= 1'b0;
      tc         <= 1'b0;
      state      <= (load_value == ZERO) ? IDLE : RUN;
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE: state <= IDLE;
        RUN: begin
          if (en) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else if (count == ONE) begin
              tc <= 1'b1;
              if (auto_reload) begin
                count <= reload_reg;
              end else begin
                count <= ZERO;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              // a zero count never decrements
              state <= IDLE;
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule
